// File: rtl/fifo_no_intf.sv
// fifo_no_intf: single-clock FIFO with registered read data and plain ports.
// Depth need not be a power of two; pointers wrap at FIFO_DEPTH-1.
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
//
// Request semantics: a write is taken on a rising edge when we=1 and the
// registered full flag is 0; a read is taken when re=1 and the registered
// empty flag is 0. Requests against the opposite flag are dropped silently,
// so full/empty act as the "ready" for the write/read side respectively.
module fifo_no_intf #(
    parameter int PNTR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 5
) (
    input  logic                  w_clk,
    input  logic                  re,
    input  logic                  we,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [PNTR_WIDTH-1:0] LP_PTR_LAST = PNTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [PNTR_WIDTH:0]   LP_DEPTH    = (PNTR_WIDTH + 1)'(FIFO_DEPTH);

    // Storage is deliberately not reset; pointers and count define validity.
    logic [DATA_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];

    logic [PNTR_WIDTH-1:0] r_wr_ptr;
    logic [PNTR_WIDTH-1:0] r_rd_ptr;
    logic [PNTR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [PNTR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [PNTR_WIDTH-1:0] w_rd_ptr_nxt;
    logic [PNTR_WIDTH:0]   w_count_nxt;

    // Qualify requests with the flags as they stood before the edge.
    always_comb begin
        w_wr_en = we && !r_full;
        w_rd_en = re && !r_empty;
    end

    // Pointer advance with wrap at the last real entry, not at 2**PNTR_WIDTH.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_wr_en) begin
            w_wr_ptr_nxt = (r_wr_ptr == LP_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
        end
        if (w_rd_en) begin
            w_rd_ptr_nxt = (r_rd_ptr == LP_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous accepted read and write leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write; no reset so the array maps onto plain RAM.
    always_ff @(posedge w_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, registered flags and read data.
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == LP_DEPTH);
            r_empty  <= (w_count_nxt == '0);
            if (w_rd_en) begin
                r_dout <= r_mem[r_rd_ptr];
            end
        end
    end

    assign dout  = r_dout;
    assign full  = r_full;
    assign empty = r_empty;

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags: any dropped request sets them until reset.
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (we && r_full) begin
                r_overflow <= 1'b1;
            end
            if (re && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_no_intf.sv
// tb_fifo_no_intf: directed bench for fifo_no_intf (default 5 x 8-bit).
// Build with FIFO_ERR_FLAGS_EN to also check the sticky error outputs.
module tb_fifo_no_intf;

    localparam int PW = 3;
    localparam int DW = 8;
    localparam int DEPTH = 5;

    logic          w_clk;
    logic          clk_run;
    logic          re;
    logic          we;
    logic          rst;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    fifo_no_intf #(
        .PNTR_WIDTH(PW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .w_clk(w_clk),
        .re(re),
        .we(we),
        .rst(rst),
        .din(din),
        .dout(dout),
        .full(full),
        .empty(empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    // Clock block: clock can be held low to show reset needs no edge.
    initial begin
        w_clk = 1'b0;
        forever begin
            #5;
            if (clk_run) w_clk = ~w_clk;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and settle away from it.
    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        we  = 1'b1;
        re  = 1'b0;
        din = d;
        tick();
        we  = 1'b0;
    endtask

    // Read one word and compare against the scoreboard head.
    task automatic pop_check(input string tag);
        logic [DW-1:0] e;
        re = 1'b1;
        we = 1'b0;
        tick();
        re = 1'b0;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underrun"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'd0, dout}, {24'd0, e});
        end
    endtask

    initial begin
        clk_run = 1'b0;
        re  = 1'b0;
        we  = 1'b0;
        rst = 1'b0;
        din = '0;

        // Reset with the clock stopped.
        #2 rst = 1'b1;
        #1;
        check("rst_dout", {24'd0, dout}, 32'h0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        clk_run = 1'b1;
        #1 rst = 1'b0;
        tick(); tick(); tick();
        check("idle_empty", {31'd0, empty}, 32'd1);
        check("idle_full", {31'd0, full}, 32'd0);
        check("idle_dout", {24'd0, dout}, 32'h0);

        // Fill.
        push_word(8'h11);
        check("fill1_empty", {31'd0, empty}, 32'd0);
        check("fill1_full", {31'd0, full}, 32'd0);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        check("fill4_full", {31'd0, full}, 32'd0);
        push_word(8'h55);
        check("fill5_full", {31'd0, full}, 32'd1);
        push_word(8'h66);
        check("ovf_full", {31'd0, full}, 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_no_udf", {31'd0, underflow}, 32'd0);
`endif

        // Drain: 0x66 must not appear.
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        for (int i = 0; i < 5; i++) begin
            pop_check("drain_dout");
            check("drain_empty", {31'd0, empty}, (i == 4) ? 32'd1 : 32'd0);
            check("drain_full", {31'd0, full}, 32'd0);
        end
        re = 1'b1;
        tick();
        re = 1'b0;
        check("udf_dout_hold", {24'd0, dout}, 32'h55);
        check("udf_empty", {31'd0, empty}, 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        check("udf_flag", {31'd0, underflow}, 32'd1);
`endif

        // Wrap-around: advance pointers to 3, then write across index 4.
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        for (int i = 0; i < 3; i++) pop_check("wrap_pre_dout");
        check("wrap_pre_empty", {31'd0, empty}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            push_word(8'hA0 + 8'(i));
            exp_q.push_back(8'hA0 + 8'(i));
        end
        check("wrap_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 5; i++) pop_check("wrap_dout");
        check("wrap_empty", {31'd0, empty}, 32'd1);

        // Simultaneous read/write with 2 entries stored.
        push_word(8'hB0);
        push_word(8'hB1);
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'hB1);
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] e;
            we  = 1'b1;
            re  = 1'b1;
            din = 8'hB2 + 8'(i);
            exp_q.push_back(din);
            tick();
            e = exp_q.pop_front();
            check("sim_dout", {24'd0, dout}, {24'd0, e});
            check("sim_full", {31'd0, full}, 32'd0);
            check("sim_empty", {31'd0, empty}, 32'd0);
        end
        we = 1'b0;
        re = 1'b0;
        // exp_q now holds B4, B5; top up to full.
        push_word(8'hC0);
        push_word(8'hC1);
        push_word(8'hC2);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hC2);
        check("sim_fill_full", {31'd0, full}, 32'd1);
        // Both requested while full: only the read happens.
        we  = 1'b1;
        re  = 1'b1;
        din = 8'hC3;
        tick();
        we  = 1'b0;
        re  = 1'b0;
        check("simf_dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
        check("simf_full", {31'd0, full}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            pop_check("simf_drain_dout");
            check("simf_drain_empty", {31'd0, empty}, (i == 3) ? 32'd1 : 32'd0);
        end
        // Both requested while empty: only the write happens, no bypass.
        we  = 1'b1;
        re  = 1'b1;
        din = 8'hD0;
        tick();
        we  = 1'b0;
        re  = 1'b0;
        check("sime_dout_hold", {24'd0, dout}, 32'hC2);
        check("sime_empty", {31'd0, empty}, 32'd0);
        check("sime_full", {31'd0, full}, 32'd0);
        exp_q.push_back(8'hD0);
        pop_check("sime_read_dout");
        check("sime_read_empty", {31'd0, empty}, 32'd1);

        // Mid-operation reset between edges.
        push_word(8'hE0);
        push_word(8'hE1);
        push_word(8'hE2);
        check("mid_pre_empty", {31'd0, empty}, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_full", {31'd0, full}, 32'd0);
        check("mid_rst_dout", {24'd0, dout}, 32'h0);
`ifdef FIFO_ERR_FLAGS_EN
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        check("mid_rst_udf", {31'd0, underflow}, 32'd0);
`endif
        #1 rst = 1'b0;
        re = 1'b1;
        tick();
        re = 1'b0;
        check("mid_read_ignored_dout", {24'd0, dout}, 32'h0);
        check("mid_read_ignored_empty", {31'd0, empty}, 32'd1);
        push_word(8'h5A);
        check("mid_wr_empty", {31'd0, empty}, 32'd0);
        exp_q.push_back(8'h5A);
        pop_check("mid_rd_dout");
        check("mid_rd_empty", {31'd0, empty}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
